// File: rtl/mem_xfer_ctrl.sv
// Moves word blocks between external memory and a local buffer: pipelined reads (up to MAX_OUTST
// in flight) for loads, serial read-capture-write per word for saves; requests hold until mem_gnt.
module mem_xfer_ctrl #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        start_save,
  input  logic        abort,
  input  logic [31:0] load_mem_addr,
  input  logic [31:0] load_words,
  input  logic [15:0] load_buf_addr,
  input  logic [31:0] save_mem_addr,
  input  logic [31:0] save_words,
  input  logic [15:0] save_buf_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        buf_wr_en,
  output logic        buf_rd_en,
  output logic [15:0] buf_addr,
  output logic [15:0] buf_wdata,
  input  logic [15:0] buf_rdata,
  output logic        busy,
  output logic        buffer_loaded,
  output logic        buffer_saved
);

  typedef enum logic [2:0] {IDLE, LOAD, SAVE_RD, SAVE_CAP, SAVE_WR, DRAIN} state_t;
  localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

  state_t      state;
  logic [31:0] base_mem, count, issued, idx;
  logic [15:0] base_buf;
  logic [3:0]  outst;
  logic        rd_gnt, rd_ret;
  logic [31:0] issued_n, idx_n;
  logic [3:0]  outst_n;

  // idx counts returned reads during a load and completed words during a save
  assign rd_gnt   = mem_req & mem_gnt & ~mem_we;
  assign rd_ret   = mem_rvalid & ((outst != 4'd0) | rd_gnt);
  assign issued_n = issued + {31'd0, rd_gnt};
  assign outst_n  = outst + {3'd0, rd_gnt} - {3'd0, rd_ret};
  assign idx_n    = idx + 32'd1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      base_mem      <= '0;
      base_buf      <= '0;
      count         <= '0;
      issued        <= '0;
      idx           <= '0;
      outst         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      buf_wr_en     <= 1'b0;
      buf_rd_en     <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      buffer_loaded <= 1'b0;
      buffer_saved  <= 1'b0;
    end else begin
      outst     <= outst_n;
      issued    <= issued_n;
      buf_wr_en <= 1'b0;
      if (abort && state != IDLE && state != DRAIN) begin
        // a read granted on this edge is already in outst_n, so the drain waits for it
        state     <= DRAIN;
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        buf_rd_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_load) begin
              buffer_loaded <= (load_words == 32'd0);
              buffer_saved  <= 1'b0;
              base_mem      <= load_mem_addr;
              base_buf      <= load_buf_addr;
              count         <= load_words;
              issued        <= '0;
              idx           <= '0;
              if (load_words != 32'd0) begin
                state    <= LOAD;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= load_mem_addr;
              end
            end else if (start_save) begin
              buffer_loaded <= 1'b0;
              buffer_saved  <= (save_words == 32'd0);
              base_mem      <= save_mem_addr;
              base_buf      <= save_buf_addr;
              count         <= save_words;
              idx           <= '0;
              if (save_words != 32'd0) begin
                state     <= SAVE_RD;
                buf_rd_en <= 1'b1;
                buf_addr  <= save_buf_addr;
              end
            end
          end
          LOAD: begin
            mem_req  <= (issued_n < count) && (outst_n < OUTST_MAX);
            mem_addr <= base_mem + issued_n;
            if (mem_rvalid) begin
              buf_wr_en <= 1'b1;
              buf_wdata <= mem_rdata;
              buf_addr  <= base_buf + idx[15:0];
              idx       <= idx_n;
            end else if (buf_wr_en && idx == count) begin
              state         <= IDLE;
              buffer_loaded <= 1'b1;
            end
          end
          SAVE_RD: begin
            buf_rd_en <= 1'b0;
            state     <= SAVE_CAP;
          end
          SAVE_CAP: begin
            mem_wdata <= buf_rdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= base_mem + idx;
            state     <= SAVE_WR;
          end
          SAVE_WR: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              idx     <= idx_n;
              if (idx_n < count) begin
                state     <= SAVE_RD;
                buf_rd_en <= 1'b1;
                buf_addr  <= base_buf + idx_n[15:0];
              end else begin
                state        <= IDLE;
                buffer_saved <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (outst_n == 4'd0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl with a memory model (programmable grant delay and read latency)
// and a 1-cycle buffer model; inputs change at negedge+2, the models act at negedge.
module tb_mem_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_load = 1'b0, start_save = 1'b0, abort = 1'b0;
  logic [31:0] load_mem_addr = '0, load_words = '0, save_mem_addr = '0, save_words = '0;
  logic [15:0] load_buf_addr = '0, save_buf_addr = '0;
  logic        mem_req, mem_we, buf_wr_en, buf_rd_en, busy, buffer_loaded, buffer_saved;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, buf_addr, buf_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0, buf_rdata = '0;

  int vectors = 0, errs = 0;
  int cyc = 0, gnt_delay = 0, lat = 3, wait_cnt = 0, out_cnt = 0, max_out = 0;
  int req_cycles = 0, busy_cyc = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [31:0] mra_log[$], mwa_log[$];
  logic [15:0] mwd_log[$], bwa_log[$], bwd_log[$], brd_log[$], dat_q[$];
  int          due_q[$];

  mem_xfer_ctrl #(.MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_save(start_save), .abort(abort),
    .load_mem_addr(load_mem_addr), .load_words(load_words), .load_buf_addr(load_buf_addr),
    .save_mem_addr(save_mem_addr), .save_words(save_words), .save_buf_addr(save_buf_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata), .busy(busy), .buffer_loaded(buffer_loaded), .buffer_saved(buffer_saved)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] buf_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  // memory and buffer models
  always @(negedge clk) begin
    cyc++;
    buf_rdata = rd_pend ? buf_fn(rd_addr) : 16'h0;
    rd_pend = buf_rd_en;
    rd_addr = buf_addr;
    if (buf_rd_en) brd_log.push_back(buf_addr);
    if (buf_wr_en) begin
      bwa_log.push_back(buf_addr);
      bwd_log.push_back(buf_wdata);
    end
    if (mem_req) req_cycles++;
    if (busy) busy_cyc++;
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= gnt_delay) begin
        mem_gnt = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          mwa_log.push_back(mem_addr);
          mwd_log.push_back(mem_wdata);
        end else begin
          mra_log.push_back(mem_addr);
          due_q.push_back(cyc + lat);
          dat_q.push_back(mem_fn(mem_addr));
          out_cnt++;
        end
      end else wait_cnt++;
    end else wait_cnt = 0;
    mem_rvalid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
      out_cnt--;
    end
    if (out_cnt > max_out) max_out = out_cnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    mra_log.delete(); mwa_log.delete(); mwd_log.delete();
    bwa_log.delete(); bwd_log.delete(); brd_log.delete();
    max_out = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic pulse(input bit ld, input bit sv);
    start_load = ld;
    start_save = sv;
    step();
    start_load = 1'b0;
    start_save = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {mem_req, mem_we, buf_wr_en, buf_rd_en, busy, buffer_loaded, buffer_saved,
              mem_addr, mem_wdata, buf_addr, buf_wdata}, '0);
  endtask

  task automatic chk_load(input string tag, input logic [31:0] ma, input logic [15:0] ba,
                          input int n);
    chk({tag, "_nrd"}, mra_log.size(), n);
    chk({tag, "_nwr"}, bwa_log.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rdaddr"}, (i < mra_log.size()) ? mra_log[i] : 32'hx, ma + 32'(i));
      chk({tag, "_bufaddr"}, (i < bwa_log.size()) ? bwa_log[i] : 16'hx, ba + 16'(i));
      chk({tag, "_bufdata"}, (i < bwd_log.size()) ? bwd_log[i] : 16'hx, mem_fn(ma + 32'(i)));
    end
    chk({tag, "_maxout"}, max_out <= 4, 1'b1);
    chk({tag, "_flags"}, {busy, buffer_loaded, buffer_saved}, 3'b010);
  endtask

  initial begin
    int snap_req, snap_busy;
    logic [15:0] exp_ba [3];
    logic [31:0] exp_ma [3];
    // reset
    rst = 1'b0;
    step(); step(); step();
    chk_all_zero("reset_during");
    rst = 1'b1;
    step();
    chk_all_zero("reset_after");

    // basic load
    clear_logs();
    gnt_delay = 0; lat = 3;
    load_mem_addr = 32'h100; load_words = 8; load_buf_addr = 16'h20;
    pulse(1'b1, 1'b0);
    chk("load_busy", busy, 1'b1);
    wait_idle("load_timeout");
    chk_load("load", 32'h100, 16'h20, 8);

    // basic save with address wrap and delayed grant
    clear_logs();
    gnt_delay = 2;
    save_mem_addr = 32'hFFFF_FFFF; save_words = 3; save_buf_addr = 16'hFFFF;
    pulse(1'b0, 1'b1);
    chk("save_flags_cleared", {busy, buffer_loaded, buffer_saved}, 3'b100);
    wait_idle("save_timeout");
    exp_ba = '{16'hFFFF, 16'h0000, 16'h0001};
    exp_ma = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    chk("save_nrd", brd_log.size(), 3);
    chk("save_nwr", mwa_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("save_bufaddr", (i < brd_log.size()) ? brd_log[i] : 16'hx, exp_ba[i]);
      chk("save_memaddr", (i < mwa_log.size()) ? mwa_log[i] : 32'hx, exp_ma[i]);
      chk("save_memdata", (i < mwd_log.size()) ? mwd_log[i] : 16'hx, buf_fn(exp_ba[i]));
    end
    chk("save_flags", {busy, buffer_loaded, buffer_saved}, 3'b001);

    // zero-count load
    gnt_delay = 0;
    load_words = 0;
    snap_req = req_cycles; snap_busy = busy_cyc;
    pulse(1'b1, 1'b0);
    chk("zero_flags", {busy, buffer_loaded, buffer_saved}, 3'b010);
    step(); step(); step();
    chk("zero_noreq", req_cycles - snap_req, 0);
    chk("zero_nobusy", busy_cyc - snap_busy, 0);

    // simultaneous start, then a save during the load
    clear_logs();
    load_mem_addr = 32'h200; load_words = 4; load_buf_addr = 16'h40;
    save_mem_addr = 32'h500; save_words = 5; save_buf_addr = 16'h60;
    pulse(1'b1, 1'b1);
    step();
    pulse(1'b0, 1'b1);
    wait_idle("simul_timeout");
    chk_load("simul", 32'h200, 16'h40, 4);
    step(); step(); step();
    chk("simul_nosave_rd", brd_log.size(), 0);
    chk("simul_nosave_wr", mwa_log.size(), 0);
    chk("simul_stay_idle", busy, 1'b0);

    // abort with three reads outstanding
    clear_logs();
    lat = 8;
    load_mem_addr = 32'h400; load_words = 10; load_buf_addr = 16'h80;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 20 && out_cnt != 3; i++) step();
    chk("abort_outst3", out_cnt, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_req_off", {mem_req, buf_wr_en, buf_rd_en, busy}, 4'b0001);
    wait_idle("abort_timeout");
    chk("abort_nrd", mra_log.size(), 3);
    chk("abort_drained", due_q.size(), 0);
    chk("abort_nobufwr", bwa_log.size(), 0);
    chk("abort_flags", {busy, buffer_loaded, buffer_saved}, 3'b000);

    // reset while a save write waits for grant
    clear_logs();
    lat = 3; gnt_delay = 3;
    save_mem_addr = 32'h700; save_words = 4; save_buf_addr = 16'h90;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 20 && !(mem_req && mem_we); i++) step();
    chk("rstsave_in_wr", {mem_req, mem_we}, 2'b11);
    rst = 1'b0;
    step();
    chk_all_zero("rstsave_during");
    rst = 1'b1;
    step();
    chk_all_zero("rstsave_after");

    // load after the reset
    clear_logs();
    gnt_delay = 0;
    load_mem_addr = 32'h300; load_words = 3; load_buf_addr = 16'h10;
    pulse(1'b1, 1'b0);
    wait_idle("postrst_timeout");
    chk_load("postrst", 32'h300, 16'h10, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
